hc595_driver: RTL and testbench

Serial transmitter for one 74HC595 or a cascaded chain of them, driving the DS/SHCP/STCP/OE pins of real or emulated shift-register hardware. It accepts a parallel word through a start/busy/done handshake and shifts it out MSB first, one SHCP rising edge per bit. After the last bit it issues a single STCP pulse so the downstream latch updates atomically. It sits between the board-level display/LED logic and the off-chip 595 pins; bit-rate pacing is internal.

---
 rtl/hc595_pkg.sv | 18 +
 rtl/hc595_tick.sv | 35 +++
 rtl/hc595_driver.sv | 122 ++++++++++++
 tb/tb_hc595_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 serial driver and any receiver-side model.
package hc595_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SH_LO,
        ST_SH_HI,
        ST_LATCH_HI,
        ST_LATCH_LO
    } hc595_state_t;

    // 595 pin polarities: OE is active low, SHCP/STCP idle low.
    localparam logic OE_ACTIVE   = 1'b0;
    localparam logic OE_INACTIVE = 1'b1;
    localparam logic CLK_IDLE    = 1'b0;
    localparam logic CLK_ACTIVE  = 1'b1;

endpackage

// File: rtl/hc595_tick.sv
// Half-period pacing counter: tick is high on the last of every DIV cycles.
module hc595_tick
    import hc595_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/hc595_driver.sv
// 74HC595 chain transmitter: shifts a parallel word out MSB first, then pulses STCP.
module hc595_driver
    import hc595_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             oe_n
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    hc595_state_t     state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ds_q, ds_d;
    logic             shcp_q, shcp_d;
    logic             stcp_q, stcp_d;
    logic             oe_n_q, oe_n_d;
    logic             tick;
    logic             tick_clr;

    // Counter restarts on every phase change and is held clear while idle.
    assign tick_clr = (state_d != state_q) || (state_q == ST_IDLE);

    hc595_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        oe_n_d   = oe_n_q;

        case (state_q)
            ST_IDLE: begin
                // The done cycle still belongs to the previous transfer.
                if (start && !done_q) begin
                    shreg_d  = data_in;
                    bitcnt_d = '0;
                    state_d  = ST_SH_LO;
                end
            end
            ST_SH_LO: begin
                if (tick) state_d = ST_SH_HI;
            end
            ST_SH_HI: begin
                if (tick) begin
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q + 1'b1;
                    state_d  = (bitcnt_q == LAST_BIT) ? ST_LATCH_HI : ST_SH_LO;
                end
            end
            ST_LATCH_HI: begin
                if (tick) state_d = ST_LATCH_LO;
            end
            ST_LATCH_LO: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    oe_n_d  = OE_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are decoded from the next state so they register alongside it.
        busy_d = (state_d != ST_IDLE);
        ds_d   = ((state_d == ST_SH_LO) || (state_d == ST_SH_HI)) ? shreg_d[WIDTH-1] : 1'b0;
        shcp_d = (state_d == ST_SH_HI)    ? CLK_ACTIVE : CLK_IDLE;
        stcp_d = (state_d == ST_LATCH_HI) ? CLK_ACTIVE : CLK_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ds_q     <= 1'b0;
            shcp_q   <= CLK_IDLE;
            stcp_q   <= CLK_IDLE;
            oe_n_q   <= OE_INACTIVE;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ds_q     <= ds_d;
            shcp_q   <= shcp_d;
            stcp_q   <= stcp_d;
            oe_n_q   <= oe_n_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ds   = ds_q;
    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign oe_n = oe_n_q;

endmodule

// File: tb/tb_hc595_driver.sv
// Bench for hc595_driver: three configurations against a cycle-timing reference and a 595 chain model.
module tb_hc595_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_r = '0;
    logic [63:0] din_r [3] = '{default: 64'd0};

    logic [2:0] busy_w, done_w, ds_w, shcp_w, stcp_w, oe_w;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    hc595_driver #(.WIDTH(8), .DIV(4)) u_a (
        .clk(clk), .rst(rst), .start(start_r[0]), .data_in(din_r[0][7:0]),
        .busy(busy_w[0]), .done(done_w[0]), .ds(ds_w[0]), .shcp(shcp_w[0]),
        .stcp(stcp_w[0]), .oe_n(oe_w[0])
    );
    hc595_driver #(.WIDTH(16), .DIV(1)) u_b (
        .clk(clk), .rst(rst), .start(start_r[1]), .data_in(din_r[1][15:0]),
        .busy(busy_w[1]), .done(done_w[1]), .ds(ds_w[1]), .shcp(shcp_w[1]),
        .stcp(stcp_w[1]), .oe_n(oe_w[1])
    );
    hc595_driver #(.WIDTH(8), .DIV(2)) u_c (
        .clk(clk), .rst(rst), .start(start_r[2]), .data_in(din_r[2][7:0]),
        .busy(busy_w[2]), .done(done_w[2]), .ds(ds_w[2]), .shcp(shcp_w[2]),
        .stcp(stcp_w[2]), .oe_n(oe_w[2])
    );

    // Behavioural 595 chain: shift on SHCP rise, copy to latch on STCP rise.
    logic [63:0] m_sr    [3] = '{default: 64'd0};
    logic [63:0] m_latch [3] = '{default: 64'd0};
    int          m_shr   [3] = '{default: 0};
    int          m_str   [3] = '{default: 0};
    logic [2:0]  m_psh = '0;
    logic [2:0]  m_pst = '0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (shcp_w[i] === 1'b1 && m_psh[i] === 1'b0) begin
                m_sr[i]  <= {m_sr[i][62:0], ds_w[i]};
                m_shr[i] <= m_shr[i] + 1;
            end
            if (stcp_w[i] === 1'b1 && m_pst[i] === 1'b0) begin
                m_latch[i] <= m_sr[i];
                m_str[i]   <= m_str[i] + 1;
            end
        end
        m_psh <= shcp_w;
        m_pst <= stcp_w;
    end

    function automatic logic [5:0] pins(input int i);
        return {busy_w[i], done_w[i], ds_w[i], shcp_w[i], stcp_w[i], oe_w[i]};
    endfunction

    function automatic logic [63:0] wmask(input int w);
        logic [63:0] one = 64'd1;
        return (w >= 64) ? '1 : ((one << w) - 1);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start_r = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (pins(i) !== 6'b000001) begin
                nbad++;
                $display("FAIL reset inst%0d pins={busy,done,ds,shcp,stcp,oe_n} got %b want 000001", i, pins(i));
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (pins(i) !== 6'b000001) begin
                nbad++;
                $display("FAIL idle_after_reset inst%0d got %b want 000001", i, pins(i));
            end
        end
    endtask

    // One transfer checked cycle by cycle against the timing rules; optionally pokes
    // start while busy and in the done cycle, both of which must be ignored.
    task automatic xfer(input int i, input int w, input int dv, input logic [63:0] d,
                        input bit poke, input string nm);
        int          t     = 2 * dv * (w + 1);
        int          shend = 2 * dv * w;
        logic [63:0] old   = m_latch[i];
        logic [63:0] m     = wmask(w);
        int          sh0   = m_shr[i];
        int          st0   = m_str[i];
        logic        oe0   = oe_w[i];
        logic [5:0]  exp_p;
        din_r[i]   = d;
        start_r[i] = 1'b1;
        for (int c = 1; c <= t + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start_r[i] = 1'b0;
                din_r[i]   = {$urandom, $urandom};
            end
            begin
                bit in_sh = (c <= shend);
                int ph    = (c - 1) % (2 * dv);
                int k     = (c - 1) / (2 * dv);
                exp_p[5] = (c <= t);
                exp_p[4] = (c == t + 1);
                exp_p[3] = in_sh ? d[w - 1 - k] : 1'b0;
                exp_p[2] = in_sh && (ph >= dv);
                exp_p[1] = (c > shend) && (c <= shend + dv);
                exp_p[0] = (c <= t) ? oe0 : 1'b0;
            end
            nvec++;
            if (pins(i) !== exp_p) begin
                nbad++;
                $display("FAIL %s cycle %0d pins={busy,done,ds,shcp,stcp,oe_n} got %b want %b",
                         nm, c, pins(i), exp_p);
            end
            if (c == shend + 1) begin
                nvec++;
                if ((m_latch[i] & m) !== (old & m)) begin
                    nbad++;
                    $display("FAIL %s latch_mid_shift got %h want %h", nm, m_latch[i] & m, old & m);
                end
            end
            if (c == shend + 2) begin
                nvec++;
                if ((m_latch[i] & m) !== (d & m)) begin
                    nbad++;
                    $display("FAIL %s latch_after_stcp got %h want %h", nm, m_latch[i] & m, d & m);
                end
            end
            if (poke) begin
                if (c == 5)     start_r[i] = 1'b1;
                if (c == 6)     start_r[i] = 1'b0;
                if (c == t + 1) start_r[i] = 1'b1;
                if (c == t + 2) start_r[i] = 1'b0;
            end
        end
        nvec++;
        if ((m_shr[i] - sh0) != w || (m_str[i] - st0) != 1) begin
            nbad++;
            $display("FAIL %s edge_count shcp_rises %0d stcp_rises %0d want %0d and 1",
                     nm, m_shr[i] - sh0, m_str[i] - st0, w);
        end
    endtask

    task automatic test_basic();
        xfer(0, 8, 4, 64'hA5, 1'b0, "a5_div4");
        xfer(0, 8, 4, 64'h3C, 1'b0, "3c_div4");
    endtask

    task automatic test_ignored_start();
        // Pokes in busy and done cycles; the next call starts one cycle after done.
        xfer(0, 8, 4, 64'h5A, 1'b1, "poke_busy_done");
        xfer(0, 8, 4, {32'd0, $urandom}, 1'b0, "start_after_done");
    endtask

    task automatic test_wide();
        xfer(1, 16, 1, 64'h8001, 1'b0, "w16_8001");
        for (int n = 0; n < 3; n++) xfer(1, 16, 1, {48'd0, 16'($urandom)}, 1'b0, "w16_rand");
    endtask

    task automatic test_reset_mid();
        logic [63:0] old = m_latch[0];
        int          st0 = m_str[0];
        din_r[0]   = {56'd0, 8'($urandom)};
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        // Land inside bit 5's shift window (cycles 41..48 for DIV=4).
        repeat (42) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (pins(0) !== 6'b000001) begin
            nbad++;
            $display("FAIL reset_mid pins got %b want 000001", pins(0));
        end
        rst = 1'b0;
        repeat (80) @(negedge clk);
        nvec++;
        if (m_latch[0] !== old || m_str[0] != st0 || pins(0) !== 6'b000001) begin
            nbad++;
            $display("FAIL reset_mid_latch latch %h stcp_rises %0d pins %b want %h %0d 000001",
                     m_latch[0], m_str[0], pins(0), old, st0);
        end
        xfer(0, 8, 4, {56'd0, 8'($urandom)}, 1'b0, "after_reset_mid");
    endtask

    // Start held high: each transfer carries the word present at its own acceptance.
    task automatic test_back_to_back();
        localparam int T = 2 * 2 * (8 + 1);
        logic [7:0] expq[$];
        logic [7:0] word = '0;
        logic       pb = 1'b0, psh = 1'b0;
        int         last_acc = -1, ndone = 0;
        din_r[2]   = {56'd0, 8'($urandom)};
        start_r[2] = 1'b1;
        for (int c = 0; c < 3 * (T + 2); c++) begin
            @(negedge clk);
            if (busy_w[2] && !pb) begin
                expq.push_back(din_r[2][7:0]);
                word = '0;
                if (last_acc >= 0) begin
                    nvec++;
                    if (c - last_acc != T + 2) begin
                        nbad++;
                        $display("FAIL b2b_period got %0d want %0d", c - last_acc, T + 2);
                    end
                end
                last_acc = c;
            end
            if (shcp_w[2] && !psh) word = {word[6:0], ds_w[2]};
            if (done_w[2]) begin
                ndone++;
                nvec++;
                if (expq.size() == 0 || word !== expq[0]) begin
                    nbad++;
                    $display("FAIL b2b_data got %h want %h", word, (expq.size() != 0) ? expq[0] : 8'hxx);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            pb  = busy_w[2];
            psh = shcp_w[2];
            din_r[2] = {56'd0, 8'($urandom)};
        end
        start_r[2] = 1'b0;
        nvec++;
        if (ndone != 3) begin
            nbad++;
            $display("FAIL b2b_count got %0d want 3", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_wide();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
